// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - byte FIFO feeding an 8N1 UART transmitter
//
// Purpose:
//   Accepts single-cycle byte strobes from a message transmitter into a
//   circular FIFO and serializes them onto a UART line (8 data bits, no
//   parity, 1 stop bit, LSB first, idle high). The producer is never
//   back-pressured: writes arriving while the FIFO is full are dropped and
//   recorded in a sticky overflow flag.
//
// Parameters:
//   CLKS_PER_BIT  i_clk cycles per UART bit (2..4095)
//   DEPTH         FIFO depth in bytes (power of two, 4..256)
//
// Ports:
//   i_clk            sole clock, all state on the rising edge
//   i_rst_n          asynchronous active-low reset
//   i_tx_byte        byte to queue, sampled when i_tx_byte_valid is high
//   i_tx_byte_valid  single-cycle write strobe
//   i_flush          synchronous FIFO discard; an in-flight frame completes
//   o_tx             registered UART serial output
//   o_busy           frame in progress or FIFO non-empty
//   o_fifo_full      FIFO holds DEPTH bytes
//   o_overflow       sticky: a write was dropped since the last flush/reset

module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_byte_valid,
  input  logic       i_flush,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_fifo_full,
  output logic       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = 12;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic          overflow_q, overflow_d;

  state_t        state_q,    state_d;
  logic [BW-1:0] baud_q,     baud_d;
  logic [2:0]    bit_idx_q,  bit_idx_d;
  logic [7:0]    shift_q,    shift_d;
  logic          tx_q,       tx_d;

  logic          push;
  logic          drop;
  logic          pop;
  logic          baud_done;
  logic          fifo_full;
  logic          fifo_empty;

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  always_comb begin
    fifo_full  = (count_q == COUNT_FULL);
    fifo_empty = (count_q == '0);

    // Accept/drop decisions use the occupancy at the start of the cycle, so
    // a pop in the same cycle does not make room for a write into a full
    // FIFO. Flush overrides everything, including the serializer's pop.
    push = i_tx_byte_valid && !i_flush && !fifo_full;
    drop = i_tx_byte_valid && !i_flush &&  fifo_full;
    pop  = (state_q == S_IDLE) && !fifo_empty && !i_flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Pointers are log2(DEPTH) wide, so the natural wrap is modulo DEPTH.
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      overflow_d = overflow_q | drop;
    end
  end

  // Storage carries no reset; only entries covered by count_q are ever read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_tx_byte;
    end
  end

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    baud_done = (baud_q == BAUD_LAST);

    // tx_d always carries the level of the state being entered, so o_tx
    // changes on the same edge as the state and stays glitch-free.
    case (state_q)
      S_IDLE: begin
        tx_d      = 1'b1;
        baud_d    = '0;
        bit_idx_d = '0;
        if (pop) begin
          shift_d = mem[rd_ptr_q];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        baud_d    = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_tx        = tx_q;
  assign o_busy      = (state_q != S_IDLE) || !fifo_empty;
  assign o_fifo_full = fifo_full;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

  localparam int C = 4;
  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       flush;
  logic       o_tx;
  logic       o_busy;
  logic       o_fifo_full;
  logic       o_overflow;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_tx_byte       (tx_byte),
    .i_tx_byte_valid (tx_valid),
    .i_flush         (flush),
    .o_tx            (o_tx),
    .o_busy          (o_busy),
    .o_fifo_full     (o_fifo_full),
    .o_overflow      (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a byte queue plus the position inside the current frame.
  // A frame is 10*C cycles: start bit, 8 data bits LSB first, stop bit.
  logic [7:0] mq[$];
  int         fpos = -1;
  logic [7:0] fbyte = 8'h00;
  logic       m_ovf = 1'b0;

  function automatic logic exp_tx();
    int b;
    if (fpos < 0) return 1'b1;
    b = fpos / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return fbyte[b-1];
    return 1'b1;
  endfunction

  task automatic model_update(input logic v, input logic [7:0] b, input logic f);
    int sz;
    logic do_pop;
    sz = mq.size();
    do_pop = (fpos < 0) && (sz > 0) && !f;
    if (do_pop) begin
      fbyte = mq.pop_front();
      fpos = 0;
    end else if (fpos >= 0) begin
      fpos = fpos + 1;
      if (fpos == 10 * C) fpos = -1;
    end
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (v) begin
      if (sz < D) mq.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  // One clock cycle: compare outputs against the model, then apply inputs.
  int last_drive_cyc = 0;
  task automatic step(input logic v, input logic [7:0] b, input logic f);
    @(negedge clk);
    check_eq("tx",       32'(o_tx),        32'(exp_tx()));
    check_eq("busy",     32'(o_busy),      32'((fpos >= 0) || (mq.size() > 0)));
    check_eq("full",     32'(o_fifo_full), 32'(mq.size() == D));
    check_eq("overflow", 32'(o_overflow),  32'(m_ovf));
    tx_valid = v;
    tx_byte  = b;
    flush    = f;
    last_drive_cyc = cyc;
    @(posedge clk);
    model_update(v, b, f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tx_valid = 1'b0;
    flush    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_tx",       32'(o_tx),        32'd1);
    check_eq("rst_busy",     32'(o_busy),      32'd0);
    check_eq("rst_full",     32'(o_fifo_full), 32'd0);
    check_eq("rst_overflow", 32'(o_overflow),  32'd0);
    mq.delete();
    fpos  = -1;
    m_ovf = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000 && !((fpos < 0) && (mq.size() == 0)); i++) step(1'b0, 8'h00, 1'b0);
    check_eq("idle_reached", 32'((fpos < 0) && (mq.size() == 0)), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  // Line monitor: decodes frames straight from o_tx, sampling mid-bit.
  logic [7:0] rx_q[$];
  int         start_cyc[$];
  logic       rx_act = 1'b0;
  logic       prev_tx = 1'b1;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act  = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!rx_act) begin
        if (prev_tx && !o_tx) begin
          rx_act = 1'b1;
          rx_cnt = 0;
          start_cyc.push_back(cyc);
        end
      end else begin
        rx_cnt = rx_cnt + 1;
        if (rx_cnt >= C + C / 2 && rx_cnt < 9 * C && ((rx_cnt - C / 2) % C) == 0)
          rx_sh[(rx_cnt - C - C / 2) / C] = o_tx;
        if (rx_cnt == 9 * C + C / 2) begin
          if (o_tx) rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end
      end
      prev_tx = o_tx;
    end
  end

  task automatic check_rx(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_count"}, 32'(rx_q.size()), 32'(exp.size()));
    if (rx_q.size() == exp.size())
      foreach (exp[i]) check_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] expb[$];
    int strobe_cyc;
    int i;

    rst_n    = 1'b1;
    tx_byte  = 8'h00;
    tx_valid = 1'b0;
    flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("por_tx",       32'(o_tx),        32'd1);
    check_eq("por_busy",     32'(o_busy),      32'd0);
    check_eq("por_full",     32'(o_fifo_full), 32'd0);
    check_eq("por_overflow", 32'(o_overflow),  32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // Single byte: latency and bit pattern.
    rx_q.delete(); start_cyc.delete();
    step(1'b1, 8'hA5, 1'b0);
    strobe_cyc = last_drive_cyc;
    wait_idle();
    expb = '{8'hA5};
    check_rx("single", expb);
    if (start_cyc.size() > 0) check_eq("latency", 32'(start_cyc[0] - strobe_cyc), 32'd2);
    else check_eq("latency_seen", 32'd0, 32'd1);

    // Burst of three on consecutive cycles: frame spacing 10*C+1.
    rx_q.delete(); start_cyc.delete();
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    wait_idle();
    expb = '{8'h55, 8'h01, 8'h80};
    check_rx("burst", expb);
    if (start_cyc.size() == 3) begin
      check_eq("spacing0", 32'(start_cyc[1] - start_cyc[0]), 32'(10 * C + 1));
      check_eq("spacing1", 32'(start_cyc[2] - start_cyc[1]), 32'(10 * C + 1));
    end else check_eq("burst_starts", 32'(start_cyc.size()), 32'd3);

    // Six strobes: last one overflows.
    rx_q.delete();
    for (i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("ovf_set", 32'(o_overflow), 32'd1);
    wait_idle();
    expb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_rx("overflow", expb);
    step(1'b0, 8'h00, 1'b1);

    // Flush during DATA with two bytes queued.
    rx_q.delete();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    for (i = 0; i < 100 && !(fpos >= 2 * C && fpos < 9 * C); i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    wait_idle();
    expb = '{8'h3C};
    check_rx("flush", expb);
    check_eq("flush_ovf", 32'(o_overflow), 32'd0);

    // Reset during bit 3, then a clean frame.
    rx_q.delete();
    step(1'b1, 8'h96, 1'b0);
    for (i = 0; i < 100 && fpos != (1 + 3) * C + 1; i++) step(1'b0, 8'h00, 1'b0);
    do_reset();
    step(1'b1, 8'h7E, 1'b0);
    wait_idle();
    expb = '{8'h7E};
    check_rx("after_reset", expb);

    // Write coinciding with a pop while the FIFO is full.
    step(1'b1, 8'hA0, 1'b0);
    for (i = 0; i < 4; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0);
    for (i = 0; i < 200 && !(fpos < 0 && mq.size() == D); i++) step(1'b0, 8'h00, 1'b0);
    check_eq("full_idle_reached", 32'(fpos < 0 && mq.size() == D), 32'd1);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("pop_write_ovf",  32'(o_overflow),  32'd1);
    check_eq("pop_write_full", 32'(o_fifo_full), 32'd0);
    wait_idle();
    step(1'b0, 8'h00, 1'b1);

    // Randomized traffic against the model.
    for (i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      else step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 96) == 0));
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
